// File: rtl/pipe_arb_pkg.sv
// Shared constants for the dual-pipeline output arbiter.
//   SRC_P1 / SRC_P2 : encoding of out_src (pipeline 1 / pipeline 2)
//   DATA_W_DEF      : default data word width
//   NUM_SRC         : number of merged sources
//   burst_w()       : width of a counter that holds 0..max_burst
package pipe_arb_pkg;

  localparam logic SRC_P1     = 1'b0;
  localparam logic SRC_P2     = 1'b1;
  localparam int   DATA_W_DEF = 32;
  localparam int   NUM_SRC    = 2;

  function automatic int burst_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/arb_skid_fifo.sv
// Two-entry FIFO buffering one pipeline's results ahead of the arbiter.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and data (ignored while full)
//   pop        : remove head (ignored while empty)
//   head       : oldest entry, valid while cnt != 0
//   cnt        : occupancy 0..2
module arb_skid_fifo
  import pipe_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        cnt
);

  // slot0 is always the head, so the read side needs no pointer.
  logic [DATA_W-1:0] slot0, slot1;
  logic              do_push, do_pop;

  assign do_push = push && (cnt != 2'd2);
  assign do_pop  = pop  && (cnt != 2'd0);
  assign head    = slot0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= din;
          else             slot1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        // Simultaneous push/pop only happens at cnt==1 (push is blocked
        // when full, pop when empty): the new word becomes the head.
        2'b11: slot0 <= din;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_out_arbiter.sv
// Round-robin merge of two pipeline result streams onto one registered
// ready/valid output, with a bounded burst length per source.
//   clk, reset             : clock, synchronous active-high reset
//   in_data_k, in_valid_k  : pipeline k result stream (k = 1, 2)
//   stall_k                : freeze pipeline k (its buffer is full)
//   out_data, out_valid    : merged output word, registered
//   out_src                : 0 = pipeline 1, 1 = pipeline 2
//   out_ready              : downstream accepts out_data
module pipe_out_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_valid_1,
  output logic              stall_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_valid_2,
  output logic              stall_2,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_src,
  input  logic              out_ready
);

  localparam int BW = burst_w(MAX_BURST);

  // Index 0 = pipeline 1, index 1 = pipeline 2 (matches out_src encoding).
  logic [NUM_SRC-1:0][DATA_W-1:0] src_data, head;
  logic [NUM_SRC-1:0][1:0]        cnt;
  logic [NUM_SRC-1:0]             src_valid, full, nempty, push, pop;

  logic          owner;
  logic [BW-1:0] burst_cnt;
  logic          other, own_ok, gnt_src, load;

  assign src_data  = {in_data_2, in_data_1};
  assign src_valid = {in_valid_2, in_valid_1};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign full[g]   = (cnt[g] == 2'd2);
    assign nempty[g] = (cnt[g] != 2'd0);
    // A stalled pipeline holds its word; it is accepted once stall drops.
    assign push[g]   = src_valid[g] && !full[g];

    arb_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .din   (src_data[g]),
      .pop   (pop[g]),
      .head  (head[g]),
      .cnt   (cnt[g])
    );
  end

  // Stall is a pure decode of the buffer count: no path from in_valid or
  // out_ready, so it cannot form a loop with the pipeline's stall logic.
  assign stall_1 = full[0];
  assign stall_2 = full[1];

  always_comb begin
    other   = ~owner;
    // Owner keeps the grant until its burst is spent, unless nobody else
    // is waiting; then it may keep going with the counter saturated.
    own_ok  = nempty[owner] && ((burst_cnt < BW'(MAX_BURST)) || !nempty[other]);
    gnt_src = own_ok ? owner : other;
    load    = (!out_valid || out_ready) && (|nempty);
    pop     = '0;
    if (load) pop[gnt_src] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_P1;
      owner     <= SRC_P1;
      burst_cnt <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= head[gnt_src];
      out_src   <= gnt_src;
      if (gnt_src == owner) begin
        if (burst_cnt != BW'(MAX_BURST)) burst_cnt <= burst_cnt + BW'(1);
      end else begin
        owner     <= gnt_src;
        burst_cnt <= BW'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_out_arbiter.sv
module tb_pipe_out_arbiter;

  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data_1, in_data_2, out_data;
  logic          in_valid_1, in_valid_2, stall_1, stall_2;
  logic          out_valid, out_src, out_ready;

  always #5 clk = ~clk;

  pipe_out_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data_1  (in_data_1),
    .in_valid_1 (in_valid_1),
    .stall_1    (stall_1),
    .in_data_2  (in_data_2),
    .in_valid_2 (in_valid_2),
    .stall_2    (stall_2),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_src    (out_src),
    .out_ready  (out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-source queues, output register, owner, burst.
  logic [31:0] mq1[$], mq2[$];
  bit          mv;
  logic [31:0] md;
  int          ms, mown, mbur;
  bit          acc[2];

  // Source drivers: each holds its word until accepted.
  bit          dv[2];
  logic [31:0] dd[2];
  logic [31:0] nxt[2];
  int          left[2];
  bit          rdy;

  // Words that completed a handshake at the DUT output.
  logic [31:0] em_d[$];
  int          em_s[$];

  task automatic m_step(input bit rst);
    int sz[2];
    int gs, oth, so, sx;
    acc[0] = 0; acc[1] = 0;
    if (rst) begin
      mq1.delete(); mq2.delete();
      mv = 0; md = 0; ms = 0; mown = 0; mbur = 0;
      return;
    end
    sz[0] = mq1.size(); sz[1] = mq2.size();
    acc[0] = dv[0] && sz[0] < 2;
    acc[1] = dv[1] && sz[1] < 2;
    if ((!mv || rdy) && (sz[0] + sz[1] > 0)) begin
      oth = 1 - mown;
      so  = sz[mown];
      sx  = sz[oth];
      gs  = (so > 0 && (mbur < MB || sx == 0)) ? mown : oth;
      md  = (gs == 1) ? mq2.pop_front() : mq1.pop_front();
      ms  = gs;
      mv  = 1;
      if (gs == mown) begin
        if (mbur < MB) mbur++;
      end else begin
        mown = gs;
        mbur = 1;
      end
    end else if (rdy) begin
      mv = 0;
    end
    if (acc[0]) mq1.push_back(dd[0]);
    if (acc[1]) mq2.push_back(dd[1]);
  endtask

  task automatic cyc(input bit rst, input int p0, input int p1, input int pr);
    int pp[2];
    pp[0] = p0; pp[1] = p1;
    for (int k = 0; k < 2; k++)
      if (!dv[k] && left[k] > 0 && $urandom_range(0, 99) < pp[k]) begin
        dv[k] = 1;
        dd[k] = nxt[k];
      end
    reset      = rst;
    in_valid_1 = dv[0]; in_data_1 = dd[0];
    in_valid_2 = dv[1]; in_data_2 = dd[1];
    rdy        = ($urandom_range(0, 99) < pr);
    out_ready  = rdy;
    if (!rst && out_valid && out_ready) begin
      em_d.push_back(out_data);
      em_s.push_back(int'(out_src));
    end
    m_step(rst);
    @(posedge clk); #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
    chk("out_data", out_data, md);
    chk("out_src", {31'b0, out_src}, ms);
    chk("stall_1", {31'b0, stall_1}, (mq1.size() == 2) ? 1 : 0);
    chk("stall_2", {31'b0, stall_2}, (mq2.size() == 2) ? 1 : 0);
    for (int k = 0; k < 2; k++)
      if (acc[k]) begin
        nxt[k]++;
        left[k]--;
        dv[k] = 0;
      end
  endtask

  task automatic drv_clear();
    for (int k = 0; k < 2; k++) begin
      dv[k] = 0; dd[k] = 0; left[k] = 0; nxt[k] = 0;
    end
  endtask

  task automatic src_load(input int k, input int n, input logic [31:0] base);
    left[k] = n;
    nxt[k]  = base;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    drv_clear();
    em_d.delete(); em_s.delete();
  endtask

  initial begin
    drv_clear();
    reset = 1; in_valid_1 = 0; in_valid_2 = 0;
    in_data_1 = 0; in_data_2 = 0; out_ready = 0;

    // Reset with both valids high: inputs ignored, nothing emitted after.
    dv[0] = 1; dd[0] = 32'hAA; dv[1] = 1; dd[1] = 32'hBB;
    cyc(1, 0, 0, 100);
    cyc(1, 0, 0, 100);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    drv_clear();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 100);
    chk("rst_no_emit", em_d.size(), 0);

    // Single source stream 1..8, full rate.
    do_reset(1);
    src_load(0, 8, 1);
    for (int i = 0; i < 12; i++) cyc(0, 100, 0, 100);
    chk("p1_count", em_d.size(), 8);
    for (int i = 0; i < em_d.size() && i < 8; i++) begin
      chk("p1_data", em_d[i], i + 1);
      chk("p1_src", em_s[i], 0);
    end

    // Both stream continuously: blocks of MB words alternate.
    do_reset(1);
    src_load(0, 100, 100);
    src_load(1, 100, 200);
    for (int i = 0; i < 20; i++) cyc(0, 100, 100, 100);
    for (int i = 0; i < 12 && i < em_d.size(); i++) begin
      chk("rr_data", em_d[i], ((i / MB) % 2 ? 200 : 100) + (i / (2 * MB)) * MB + i % MB);
      chk("rr_src", em_s[i], (i / MB) % 2);
    end

    // Backpressure: hold output, stall, then drain in order.
    do_reset(1);
    src_load(0, 6, 1);
    for (int i = 0; i < 5; i++) cyc(0, 100, 0, 0);
    chk("bp_hold_data", out_data, 1);
    chk("bp_stall", {31'b0, stall_1}, 1);
    for (int i = 0; i < 12; i++) cyc(0, 100, 0, 100);
    chk("bp_count", em_d.size(), 6);
    for (int i = 0; i < em_d.size() && i < 6; i++) chk("bp_data", em_d[i], i + 1);

    // Owner p1 mid-burst with empty buffer: lone p2 word wins next load.
    do_reset(1);
    src_load(0, 2, 1);
    for (int i = 0; i < 4; i++) cyc(0, 100, 0, 100);
    src_load(1, 1, 32'h55);
    for (int i = 0; i < 4; i++) cyc(0, 0, 100, 100);
    chk("sw_count", em_d.size(), 3);
    if (em_d.size() == 3) begin
      chk("sw_data", em_d[2], 32'h55);
      chk("sw_src", em_s[2], 1);
    end

    // Reset while everything is full and blocked.
    do_reset(1);
    src_load(0, 10, 300);
    src_load(1, 10, 400);
    for (int i = 0; i < 8; i++) cyc(0, 100, 100, 0);
    chk("full_s1", {31'b0, stall_1}, 1);
    chk("full_s2", {31'b0, stall_2}, 1);
    do_reset(1);
    chk("fr_valid", {31'b0, out_valid}, 0);
    chk("fr_s1", {31'b0, stall_1}, 0);
    chk("fr_s2", {31'b0, stall_2}, 0);
    src_load(1, 1, 7);
    for (int i = 0; i < 4; i++) cyc(0, 0, 100, 100);
    chk("fr_count", em_d.size(), 1);
    if (em_d.size() >= 1) begin
      chk("fr_data", em_d[0], 7);
      chk("fr_src", em_s[0], 1);
    end

    // Random traffic, backpressure and occasional reset.
    do_reset(1);
    src_load(0, 1 << 20, 32'h1000_0000);
    src_load(1, 1 << 20, 32'h2000_0000);
    begin
      int p0, p1, pr;
      p0 = 50; p1 = 50; pr = 50;
      for (int i = 0; i < 3000; i++) begin
        if (i % 50 == 0) begin
          p0 = $urandom_range(0, 100);
          p1 = $urandom_range(0, 100);
          pr = $urandom_range(10, 100);
        end
        cyc(($urandom_range(0, 199) == 0), p0, p1, pr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
